// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues in-order imem fetches,
// buffers returned words and flushes on redirect.
module fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic [ADDR_WIDTH-1:0] instr_pc_plus4
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0] DEPTH_U = (CW + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] pc;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         drop_cnt;
  logic [CW-1:0]         count;
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [PW-1:0]         iwptr;
  logic [PW-1:0]         irptr;

  logic [DATA_WIDTH-1:0] buf_data [DEPTH];
  logic [ADDR_WIDTH-1:0] buf_pc [DEPTH];
  logic [ADDR_WIDTH-1:0] inflight_pc [DEPTH];

  logic          pop;
  logic          issue;
  logic          push;
  logic          drop;
  logic [CW:0]   used;

  // A same-cycle pop frees a slot, which keeps 1 instr/cycle at L=1
  assign instr_valid = (count != '0);
  assign pop   = instr_valid && instr_ready && !redirect;
  assign used  = {1'b0, outstanding} + {1'b0, count}
               - {{CW{1'b0}}, pop};
  assign imem_req_valid = rst_n && !redirect && (used < DEPTH_U);
  assign imem_addr = pc;
  assign issue = imem_req_valid && imem_req_ready;
  assign drop  = imem_rsp_valid && (drop_cnt != '0);
  assign push  = imem_rsp_valid && (drop_cnt == '0) && !redirect;

  assign instr = instr_valid ? buf_data[rptr] : '0;
  assign instr_pc = instr_valid ? buf_pc[rptr] : '0;
  assign instr_pc_plus4 = instr_valid
                        ? buf_pc[rptr] + ADDR_WIDTH'(4) : '0;

  // PC, credit and stale-response accounting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      iwptr       <= '0;
      irptr       <= '0;
    end else begin
      if (redirect)
        pc <= redirect_pc & ~ADDR_WIDTH'(3);
      else if (issue)
        pc <= pc + ADDR_WIDTH'(4);
      outstanding <= outstanding + CW'(issue)
                   - CW'(imem_rsp_valid);
      if (redirect)
        drop_cnt <= outstanding - CW'(imem_rsp_valid);
      else if (drop)
        drop_cnt <= drop_cnt - CW'(1);
      if (issue)
        iwptr <= iwptr + PW'(1);
      if (imem_rsp_valid)
        irptr <= irptr + PW'(1);
    end
  end

  // Instruction buffer pointers; redirect empties it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (redirect) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)
        wptr <= wptr + PW'(1);
      if (pop)
        rptr <= rptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage: issue-time PCs and returned words
  always_ff @(posedge clk) begin
    if (issue)
      inflight_pc[iwptr] <= pc;
    if (push) begin
      buf_data[wptr] <= imem_rsp_data;
      buf_pc[wptr]   <= inflight_pc[irptr];
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == DEPTH_C)));

  a_solicited: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && (outstanding == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus
// hand sequences for fetch_unit.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          fresh;
    int          lat;
    bit          ir;
    bit          rd;
    logic [31:0] rpc;
    bit          ev;
    logic [31:0] epc;
    bit          erv;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tbl[$];
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int cyc;
  int lat;
  int nchk;
  int nfail;

  function automatic logic [31:0] word_of(logic [31:0] a);
    return a ^ 32'h5A3C_96E1;
  endfunction

  function automatic void v(bit fr, int l, bit ir, bit rd,
                            logic [31:0] rpc, bit ev,
                            logic [31:0] epc, bit erv,
                            logic [31:0] ea);
    tbl.push_back('{fr, l, ir, rd, rpc, ev, epc, erv, ea});
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc_a();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    #1;
    if (imem_req_valid && imem_req_ready) begin
      mq_addr.push_back(imem_addr);
      mq_due.push_back(cyc + lat);
    end
  endtask

  task automatic cyc_b();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    rst_n          = 1'b0;
    mq_addr.delete();
    mq_due.delete();
    #1;
    chk("rst req_valid", imem_req_valid, 0);
    chk("rst instr_valid", instr_valid, 0);
    chk("rst instr", instr, 0);
    chk("rst instr_pc", instr_pc, 0);
    chk("rst pc_plus4", instr_pc_plus4, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    logic [31:0] exp_pc;
    int got;
    nchk = 0;
    nfail = 0;
    cyc = 0;
    lat = 1;
    rst_n = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    redirect = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;

    // streaming at L=1
    v(1,1, 1,0,0,           0,0,           1,0);
    v(0,1, 1,0,0,           0,0,           1,4);
    v(0,1, 1,0,0,           1,0,           1,8);
    v(0,1, 1,0,0,           1,4,           1,12);
    v(0,1, 1,0,0,           1,8,           1,16);
    v(0,1, 1,0,0,           1,12,          1,20);
    // decode stall: only DEPTH requests
    v(1,1, 0,0,0,           0,0,           1,0);
    v(0,1, 0,0,0,           0,0,           1,4);
    v(0,1, 0,0,0,           1,0,           0,0);
    v(0,1, 0,0,0,           1,0,           0,0);
    v(0,1, 0,0,0,           1,0,           0,0);
    v(0,1, 0,0,0,           1,0,           0,0);
    v(0,1, 1,0,0,           1,0,           1,8);
    v(0,1, 1,0,0,           1,4,           1,12);
    v(0,1, 1,0,0,           1,8,           1,16);
    // L=3 redirect drops two stale fetches
    v(1,3, 1,0,0,           0,0,           1,0);
    v(0,3, 1,0,0,           0,0,           1,4);
    v(0,3, 1,1,32'h103,     0,0,           0,0);
    v(0,3, 1,0,0,           0,0,           0,0);
    v(0,3, 1,0,0,           0,0,           1,32'h100);
    v(0,3, 1,0,0,           0,0,           1,32'h104);
    v(0,3, 1,0,0,           0,0,           0,0);
    v(0,3, 1,0,0,           0,0,           0,0);
    v(0,3, 1,0,0,           1,32'h100,     1,32'h108);
    v(0,3, 1,0,0,           1,32'h104,     1,32'h10C);
    // redirect with rsp and pop in same cycle
    v(1,1, 1,0,0,           0,0,           1,0);
    v(0,1, 1,0,0,           0,0,           1,4);
    v(0,1, 1,1,32'h200,     1,0,           0,0);
    v(0,1, 1,0,0,           0,0,           1,32'h200);
    v(0,1, 1,0,0,           0,0,           1,32'h204);
    v(0,1, 1,0,0,           1,32'h200,     1,32'h208);
    // PC wrap-around
    v(1,1, 1,0,0,           0,0,           1,0);
    v(0,1, 1,1,32'hFFFF_FFF8, 0,0,         0,0);
    v(0,1, 1,0,0,           0,0,           1,32'hFFFF_FFF8);
    v(0,1, 1,0,0,           0,0,           1,32'hFFFF_FFFC);
    v(0,1, 1,0,0,           1,32'hFFFF_FFF8, 1,0);
    v(0,1, 1,0,0,           1,32'hFFFF_FFFC, 1,4);
    v(0,1, 1,0,0,           1,0,           1,8);
    // back-to-back redirects, later wins
    v(1,3, 1,0,0,           0,0,           1,0);
    v(0,3, 1,0,0,           0,0,           1,4);
    v(0,3, 1,1,32'h300,     0,0,           0,0);
    v(0,3, 1,1,32'h400,     0,0,           0,0);
    v(0,3, 1,0,0,           0,0,           1,32'h400);
    v(0,3, 1,0,0,           0,0,           1,32'h404);
    v(0,3, 1,0,0,           0,0,           0,0);
    v(0,3, 1,0,0,           0,0,           0,0);
    v(0,3, 1,0,0,           1,32'h400,     1,32'h408);

    @(negedge clk);
    foreach (tbl[i]) begin
      if (tbl[i].fresh) begin
        lat = tbl[i].lat;
        do_reset();
      end
      imem_req_ready = 1'b1;
      instr_ready = tbl[i].ir;
      redirect = tbl[i].rd;
      redirect_pc = tbl[i].rpc;
      cyc_a();
      chk($sformatf("row%0d valid", i), instr_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("row%0d pc", i), instr_pc, tbl[i].epc);
        chk($sformatf("row%0d instr", i), instr,
            word_of(tbl[i].epc));
        chk($sformatf("row%0d plus4", i), instr_pc_plus4,
            tbl[i].epc + 32'd4);
      end
      chk($sformatf("row%0d req_valid", i), imem_req_valid,
          tbl[i].erv);
      if (tbl[i].erv)
        chk($sformatf("row%0d addr", i), imem_addr,
            tbl[i].eaddr);
      cyc_b();
      redirect = 1'b0;
    end

    // toggling req_ready, random decode stalls
    lat = 1;
    do_reset();
    exp_pc = '0;
    got = 0;
    for (int k = 0; k < 1000 && got < 100; k++) begin
      imem_req_ready = (k % 2 == 0);
      instr_ready = 1'($urandom_range(0, 1));
      cyc_a();
      if (instr_valid && instr_ready) begin
        chk("seq pc", instr_pc, exp_pc);
        chk("seq instr", instr, word_of(exp_pc));
        exp_pc = exp_pc + 32'd4;
        got++;
      end
      cyc_b();
    end
    chk("seq delivered", got, 100);

    // async reset mid-stream
    lat = 3;
    do_reset();
    instr_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc_a();
      cyc_b();
    end
    cyc_a();
    chk("pre-rst valid", instr_valid, 1);
    chk("pre-rst pc", instr_pc, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async valid", instr_valid, 0);
    chk("async instr", instr, 0);
    chk("async pc", instr_pc, 0);
    chk("async plus4", instr_pc_plus4, 0);
    chk("async req_valid", imem_req_valid, 0);
    imem_rsp_valid = 1'b0;
    mq_addr.delete();
    mq_due.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    lat = 1;
    instr_ready = 1'b1;
    cyc_a();
    chk("post-rst req_valid", imem_req_valid, 1);
    chk("post-rst addr", imem_addr, 0);
    cyc_b();
    cyc_a();
    cyc_b();
    cyc_a();
    chk("post-rst valid", instr_valid, 1);
    chk("post-rst pc", instr_pc, 0);
    chk("post-rst instr", instr, word_of(32'h0));
    cyc_b();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nchk, nfail);
    $finish;
  end

endmodule
